// File: rtl/seq_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_scan_pkg
// Description : Shared definitions for the serial scan controller: default
//               parameter values and the controller state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_scan_pkg;

    // Default widths: window bits, bit-budget counter, hit counter.
    localparam int unsigned C_DEF_PAT_W = 4;
    localparam int unsigned C_DEF_LEN_W = 8;
    localparam int unsigned C_DEF_CNT_W = 8;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_t;

endpackage : seq_scan_pkg
`default_nettype wire

// File: rtl/seq_match_win.sv
`default_nettype none
// ============================================================================
// Module      : seq_match_win
// Description : Serial match window. Shifts stream bits in at the LSB, keeps
//               a saturating fill count and compares the would-be window
//               against a masked pattern. The match flag is combinational and
//               describes the bit being shifted in this cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_match_win
    import seq_scan_pkg::*;
#(
    parameter int PAT_W = C_DEF_PAT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift_en_i,
    input  logic             clear_i,
    input  logic             overlap_i,
    input  logic             din_i,
    input  logic [PAT_W-1:0] pattern_i,
    input  logic [PAT_W-1:0] mask_i,
    output logic             match_o
);

    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] C_FULL = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  win_q;
    logic [PAT_W-1:0]  win_d;
    logic [FILL_W-1:0] fill_q;
    logic [FILL_W-1:0] fill_d;
    logic [PAT_W-1:0]  w_next_win;
    logic [FILL_W-1:0] w_next_fill;
    logic              w_match;

    // Compare the window as it will look once the incoming bit is in, and
    // drop the fill count after a match when overlaps are not allowed.
    always_comb begin
        w_next_win  = {win_q[PAT_W-2:0], din_i};
        w_next_fill = (fill_q == C_FULL) ? C_FULL : fill_q + FILL_W'(1);
        w_match     = shift_en_i
                      && (((w_next_win ^ pattern_i) & mask_i) == '0)
                      && (w_next_fill == C_FULL);
        win_d  = win_q;
        fill_d = fill_q;
        if (clear_i) begin
            win_d  = '0;
            fill_d = '0;
        end else if (shift_en_i) begin
            win_d  = w_next_win;
            fill_d = (w_match && !overlap_i) ? '0 : w_next_fill;
        end
    end

    // Window and fill count registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            win_q  <= '0;
            fill_q <= '0;
        end else begin
            win_q  <= win_d;
            fill_q <= fill_d;
        end
    end

    assign match_o = w_match;

endmodule : seq_match_win
`default_nettype wire

// File: rtl/seq_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seq_scan_ctrl
// Description : Programmable serial scan controller. Accepts a scan job over
//               a valid/ready configuration port, paces stream bits through
//               a masked match window, counts hits and retires the job with a
//               one-cycle done pulse.
//               Optional feature macro SEQ_SCAN_FIRST_POS_EN adds the
//               first_hit_pos output (position of the first match in a job).
// Revision    : 1.0 - initial release
// ============================================================================
module seq_scan_ctrl
    import seq_scan_pkg::*;
#(
    parameter int PAT_W = C_DEF_PAT_W,
    parameter int LEN_W = C_DEF_LEN_W,
    parameter int CNT_W = C_DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [PAT_W-1:0] cfg_mask,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [CNT_W-1:0] cfg_max_hits,
    input  logic             cfg_overlap,
    input  logic             din_valid,
    input  logic             din,
    output logic             din_ready,
    input  logic             abort,
    output logic             busy,
    output logic             hit,
    output logic             done,
    output logic [CNT_W-1:0] hit_count,
    output logic [LEN_W-1:0] bits_seen
`ifdef SEQ_SCAN_FIRST_POS_EN
    ,
    output logic [LEN_W-1:0] first_hit_pos
`endif
);

    scan_state_t      state_q;
    scan_state_t      state_d;
    logic [PAT_W-1:0] pattern_q;
    logic [PAT_W-1:0] pattern_d;
    logic [PAT_W-1:0] mask_q;
    logic [PAT_W-1:0] mask_d;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_d;
    logic [CNT_W-1:0] max_hits_q;
    logic [CNT_W-1:0] max_hits_d;
    logic             overlap_q;
    logic             overlap_d;
    logic [CNT_W-1:0] hit_count_q;
    logic [CNT_W-1:0] hit_count_d;
    logic [LEN_W-1:0] bits_seen_q;
    logic [LEN_W-1:0] bits_seen_d;
    logic             hit_q;
    logic             hit_d;

    logic             w_cfg_take;
    logic             w_accept;
    logic             w_match;

    // Handshake qualifiers: a job is taken only in IDLE, a bit only in SCAN
    // and never in a cycle where abort is raised.
    always_comb begin
        w_cfg_take = (state_q == IDLE) && cfg_valid;
        w_accept   = (state_q == SCAN) && din_valid && !abort;
    end

    seq_match_win #(
        .PAT_W      (PAT_W)
    ) u_win (
        .clk        (clk),
        .reset      (reset),
        .shift_en_i (w_accept),
        .clear_i    (w_cfg_take),
        .overlap_i  (overlap_q),
        .din_i      (din),
        .pattern_i  (pattern_q),
        .mask_i     (mask_q),
        .match_o    (w_match)
    );

    // Next-state logic: job latch, counters and termination decisions.
    always_comb begin
        state_d     = state_q;
        pattern_d   = pattern_q;
        mask_d      = mask_q;
        len_d       = len_q;
        max_hits_d  = max_hits_q;
        overlap_d   = overlap_q;
        hit_count_d = hit_count_q;
        bits_seen_d = bits_seen_q;
        hit_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    pattern_d   = cfg_pattern;
                    mask_d      = cfg_mask;
                    len_d       = cfg_len;
                    max_hits_d  = cfg_max_hits;
                    overlap_d   = cfg_overlap;
                    hit_count_d = '0;
                    bits_seen_d = '0;
                    state_d     = (cfg_len == '0) ? DONE : SCAN;
                end
            end
            SCAN: begin
                if (abort) begin
                    state_d = DONE;
                end else if (w_accept) begin
                    bits_seen_d = bits_seen_q + LEN_W'(1);
                    if (w_match) begin
                        hit_d = 1'b1;
                        if (hit_count_q != '1) begin
                            hit_count_d = hit_count_q + CNT_W'(1);
                        end
                    end
                    // Terminate on the same edge that accepts the last bit
                    // or the hit that reaches the limit.
                    if ((bits_seen_d == len_q)
                        || ((max_hits_q != '0) && (hit_count_d == max_hits_q))) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, job configuration and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            pattern_q   <= '0;
            mask_q      <= '0;
            len_q       <= '0;
            max_hits_q  <= '0;
            overlap_q   <= 1'b0;
            hit_count_q <= '0;
            bits_seen_q <= '0;
            hit_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pattern_q   <= pattern_d;
            mask_q      <= mask_d;
            len_q       <= len_d;
            max_hits_q  <= max_hits_d;
            overlap_q   <= overlap_d;
            hit_count_q <= hit_count_d;
            bits_seen_q <= bits_seen_d;
            hit_q       <= hit_d;
        end
    end

    // Status outputs decoded from the state and the registered counters.
    always_comb begin
        cfg_ready = (state_q == IDLE);
        din_ready = (state_q == SCAN) && !abort;
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);
        hit       = hit_q;
        hit_count = hit_count_q;
        bits_seen = bits_seen_q;
    end

`ifdef SEQ_SCAN_FIRST_POS_EN
    logic [LEN_W-1:0] first_pos_q;
    logic [LEN_W-1:0] first_pos_d;

    // All-ones marks "no match yet"; it cannot collide with a real position
    // because bits_seen never exceeds the all-ones budget.
    always_comb begin
        first_pos_d = first_pos_q;
        if (w_cfg_take) begin
            first_pos_d = '1;
        end else if (w_accept && w_match && (first_pos_q == '1)) begin
            first_pos_d = bits_seen_q;
        end
    end

    // First-match position register.
    always_ff @(posedge clk) begin
        if (reset) begin
            first_pos_q <= '1;
        end else begin
            first_pos_q <= first_pos_d;
        end
    end

    assign first_hit_pos = first_pos_q;
`endif

endmodule : seq_scan_ctrl
`default_nettype wire
